conv_mac_sequencer: RTL and testbench

Sequences one shared combinational multiplier over a K×K convolution window to produce all valid output pixels of an N×N unsigned image with a signed filter. Generates image and filter read addresses, drives the multiplier operands and enable, accumulates the K·K products per output pixel, and presents each result on a valid/ready output port. Sits between the image/filter storage and the next CNN layer or result buffer.

---
 rtl/conv_mac_sequencer.sv | 147 ++++++++++++++
 tb/tb_conv_mac_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_sequencer.sv
// Convolution MAC sequencer: walks a KxK window over an NxN image with one shared multiplier.
// Optional feature: define CONV_RELU_EN to clamp negative window sums to zero on the output.
module conv_mac_sequencer #(
    parameter int X     = 4,
    parameter int K     = 3,
    parameter int N     = 6,
    parameter int ACC_W = 2*X+4,
    localparam int M    = N - K + 1,
    localparam int IAW  = (N*N > 1) ? $clog2(N*N) : 1,
    localparam int FAW  = (K*K > 1) ? $clog2(K*K) : 1,
    localparam int CW   = (M > 1) ? $clog2(M) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Start,
    output logic [IAW-1:0]          img_addr,
    input  logic [X-1:0]            img_data,
    output logic [FAW-1:0]          flt_addr,
    input  logic [X-1:0]            flt_data,
    output logic                    mul_start,
    output logic [X-1:0]            mul_din0,
    output logic [X-1:0]            mul_din1,
    input  logic [2*X-1:0]          mul_dout,
    output logic signed [ACC_W-1:0] out_data,
    output logic [CW-1:0]           out_row,
    output logic [CW-1:0]           out_col,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    logic [CW-1:0]           row;
    logic [CW-1:0]           col;
    logic [KW-1:0]           ki;
    logic [KW-1:0]           kj;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prodExt;
    logic signed [ACC_W-1:0] sum;
    logic                    firstTap;
    logic                    lastTap;
    logic                    lastPixel;

    // Addresses are decoded straight from the window counters so the read data,
    // and therefore the product, belongs to the tap being accumulated this cycle.
    assign img_addr  = IAW'((int'(row) + int'(ki)) * N + int'(col) + int'(kj));
    assign flt_addr  = FAW'(int'(ki) * K + int'(kj));
    assign mul_din0  = img_data;
    assign mul_din1  = flt_data;
    assign out_row   = row;
    assign out_col   = col;

    assign prodExt   = {{(ACC_W-2*X){mul_dout[2*X-1]}}, mul_dout};
    assign firstTap  = (ki == '0) && (kj == '0);
    assign lastTap   = (ki == KW'(K-1)) && (kj == KW'(K-1));
    assign lastPixel = (row == CW'(M-1)) && (col == CW'(M-1));
    assign sum       = (firstTap ? '0 : acc) + prodExt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            ki        <= '0;
            kj        <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mul_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                    ki  <= '0;
                    kj  <= '0;
                    acc <= '0;
                    if (Start) begin
                        state     <= MAC;
                        busy      <= 1'b1;
                        mul_start <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= sum;
                    if (lastTap) begin
`ifdef CONV_RELU_EN
                        out_data <= sum[ACC_W-1] ? '0 : sum;
`else
                        out_data <= sum;
`endif
                        out_valid <= 1'b1;
                        mul_start <= 1'b0;
                        state     <= HOLD;
                    end else if (kj == KW'(K-1)) begin
                        kj <= '0;
                        ki <= ki + 1'b1;
                    end else begin
                        kj <= kj + 1'b1;
                    end
                end
                HOLD: begin
                    // Counters stay frozen until the consumer takes the result.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ki        <= '0;
                        kj        <= '0;
                        if (lastPixel) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            if (col == CW'(M-1)) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                            mul_start <= 1'b1;
                            state     <= MAC;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    row   <= '0;
                    col   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer on a 4x4 image with a 3x3 filter.
// Expected window sums are computed from the bench's own image and filter arrays.
module tb_conv_mac_sequencer;

    localparam int X     = 4;
    localparam int K     = 3;
    localparam int N     = 4;
    localparam int M     = N - K + 1;
    localparam int ACC_W = 2*X + 4;
    localparam int FRAME = M*M*(K*K+1);

    typedef struct {
        int row;
        int col;
        int data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    Start = 1'b0;
    logic [3:0]              img_addr;
    logic [X-1:0]            img_data;
    logic [3:0]              flt_addr;
    logic [X-1:0]            flt_data;
    logic                    mul_start;
    logic [X-1:0]            mul_din0;
    logic [X-1:0]            mul_din1;
    logic [2*X-1:0]          mul_dout;
    logic signed [ACC_W-1:0] out_data;
    logic [0:0]              out_row;
    logic [0:0]              out_col;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic                    busy;
    logic                    done;

    logic [X-1:0]        img [0:15];
    logic signed [X-1:0] flt [0:15];
    exp_t                sbq [$];
    exp_t                monE;
    int                  compareCount = 0;
    int                  failCount = 0;
    int                  cyc = 0;

    conv_mac_sequencer #(.X(X), .K(K), .N(N), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .Start(Start),
        .img_addr(img_addr), .img_data(img_data),
        .flt_addr(flt_addr), .flt_data(flt_data),
        .mul_start(mul_start), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout), .out_data(out_data),
        .out_row(out_row), .out_col(out_col),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Storage and multiplier models around the sequencer
    assign img_data = img[img_addr];
    assign flt_data = flt[flt_addr];
    assign mul_dout = 8'($signed({4'b0, mul_din0}) * $signed({{4{mul_din1[3]}}, mul_din1}));

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Load image/filter patterns and queue the window sums the frame should produce
    task automatic applyStimulus(input int imgMode, input int fltMode, input bit pushExpected);
        exp_t e;
        int   s;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r*N+c] = (imgMode == 0) ? 4'd1 : (imgMode == 1) ? 4'd15 : 4'((r*N+c) % 16);
        for (int i = 0; i < 16; i++)
            flt[i] = (fltMode == 0) ? 4'sd1 : (fltMode == 1) ? -4'sd8 : ((i == 4) ? 4'sd1 : 4'sd0);
        if (pushExpected) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < M; c++) begin
                    s = 0;
                    for (int a = 0; a < K; a++)
                        for (int b = 0; b < K; b++)
                            s += int'(img[(r+a)*N + c + b]) * int'(flt[a*K+b]);
`ifdef CONV_RELU_EN
                    if (s < 0) s = 0;
`endif
                    e.row  = r;
                    e.col  = c;
                    e.data = s;
                    sbq.push_back(e);
                end
            end
        end
    endtask

    task automatic resetCheck(input string tag);
        checkOutput({tag, "_img_addr"}, 32'(img_addr), 0);
        checkOutput({tag, "_flt_addr"}, 32'(flt_addr), 0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 0);
        checkOutput({tag, "_out_row"}, 32'(out_row), 0);
        checkOutput({tag, "_out_col"}, 32'(out_col), 0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_mul_start"}, 32'(mul_start), 0);
    endtask

    // Pulse Start, optionally stall the first result, optionally poke Start mid-frame
    task automatic runFrame(input string tag, input int stall, input bit pokeStart);
        int  tStart;
        int  stallLeft;
        bit  seen;
        stallLeft = stall;
        seen      = 1'b0;
        @(posedge clk); #1;
        out_ready = (stall == 0);
        Start     = 1'b1;
        @(posedge clk); #1;
        tStart = cyc;
        Start  = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checkOutput({tag, "_tap0_mul_start"}, 32'(mul_start), 1);
                checkOutput({tag, "_tap0_busy"}, 32'(busy), 1);
                checkOutput({tag, "_tap0_flt_addr"}, 32'(flt_addr), 0);
                checkOutput({tag, "_tap0_img_addr"}, 32'(img_addr), 0);
            end else if (i == 1) begin
                checkOutput({tag, "_tap1_flt_addr"}, 32'(flt_addr), 1);
                checkOutput({tag, "_tap1_img_addr"}, 32'(img_addr), 1);
            end else if (i == 8) begin
                checkOutput({tag, "_tap8_flt_addr"}, 32'(flt_addr), 8);
                checkOutput({tag, "_tap8_img_addr"}, 32'(img_addr), 2*N+2);
            end
            if (done) begin
                seen = 1'b1;
                checkOutput({tag, "_len"}, 32'(cyc - tStart), FRAME + stall);
                checkOutput({tag, "_busy_at_done"}, 32'(busy), 0);
            end else begin
                if (stallLeft > 0 && out_valid) begin
                    checkOutput({tag, "_stall_valid"}, 32'(out_valid), 1);
                    checkOutput({tag, "_stall_data"}, 32'(out_data), sbq[0].data);
                    checkOutput({tag, "_stall_row"}, 32'(out_row), 0);
                    checkOutput({tag, "_stall_col"}, 32'(out_col), 0);
                    checkOutput({tag, "_stall_mul_start"}, 32'(mul_start), 0);
                    stallLeft--;
                end
                @(posedge clk); #1;
                out_ready = (stallLeft == 0);
                if (pokeStart) Start = (i == 15);
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 1);
        Start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_done_pulse_end"}, 32'(done), 0);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 0);
        checkOutput({tag, "_sb_drained"}, 32'(sbq.size()), 0);
    endtask

    // Scoreboard consumer: every accepted handshake pops one expected result
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checkOutput("sb_has_entry", 32'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                monE = sbq.pop_front();
                checkOutput("out_data", 32'(out_data), monE.data);
                checkOutput("out_row", 32'(out_row), monE.row);
                checkOutput("out_col", 32'(out_col), monE.col);
            end
        end
    end

    // Directed sequence of frames
    initial begin
        applyStimulus(0, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetCheck("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] frame: ones image, ones filter");
        applyStimulus(0, 0, 1'b1);
        runFrame("ones", 0, 1'b0);

        $display("[TB] frame: max image, -8 filter");
        applyStimulus(1, 1, 1'b1);
        runFrame("neg", 0, 1'b0);

        $display("[TB] frame: ramp image, identity filter, stalled first result");
        applyStimulus(2, 2, 1'b1);
        runFrame("stall", 5, 1'b0);

        $display("[TB] frame: Start poked while busy");
        applyStimulus(0, 0, 1'b1);
        runFrame("poke", 0, 1'b1);

        $display("[TB] reset in the middle of MAC");
        applyStimulus(1, 1, 1'b0);
        @(posedge clk); #1;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        resetCheck("abort");
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", 32'(done), 0);
        checkOutput("abort_no_valid", 32'(out_valid), 0);

        applyStimulus(2, 2, 1'b1);
        runFrame("fresh", 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
